// File: rtl/unidad_corrimiento_secuencial.sv
// Sequential shift/rotate unit: one single-bit step per clock under a start/ready/done handshake.
// Optional carry-out register C is compiled in with UNIDAD_CORR_CARRY_EN.
module unidad_corrimiento_secuencial #(
  parameter  int N  = 8,
  localparam int DW = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic signed [N-1:0] F,
  input  logic        [2:0]   H,
  input  logic        [DW-1:0] D,
  output logic                ready,
  output logic                busy,
  output logic                done,
`ifdef UNIDAD_CORR_CARRY_EN
  output logic                C,
`endif
  output logic signed [N-1:0] S
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [2:0] OP_XFER = 3'b000;
  localparam logic [2:0] OP_SHL  = 3'b001;
  localparam logic [2:0] OP_SHR  = 3'b010;
  localparam logic [2:0] OP_CLR  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
  localparam logic [2:0] OP_ASL  = 3'b110;
  localparam logic [2:0] OP_ASR  = 3'b111;

  state_t        state, state_n;
  logic [2:0]    hop;
  logic [DW-1:0] cnt;
  logic [N-1:0]  step;
  logic          step_c;
  logic          accept;

  assign ready  = (state != SHIFT);
  assign busy   = (state == SHIFT);
  assign done   = (state == DONE);
  assign accept = ready && start;

  // One 1-bit step of the latched op, plus the bit that leaves (or wraps) for the carry.
  always_comb begin
    step   = S;
    step_c = 1'b0;
    case (hop)
      OP_SHL, OP_ASL: begin step = {S[N-2:0], 1'b0};    step_c = S[N-1]; end
      OP_SHR:         begin step = {1'b0, S[N-1:1]};    step_c = S[0];   end
      OP_ASR:         begin step = {S[N-1], S[N-1:1]};  step_c = S[0];   end
      OP_ROL:         begin step = {S[N-2:0], S[N-1]};  step_c = S[N-1]; end
      OP_ROR:         begin step = {S[0], S[N-1:1]};    step_c = S[0];   end
      default:        begin step = S;                   step_c = 1'b0;   end
    endcase
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          if (H == OP_XFER || H == OP_CLR || D == '0) state_n = DONE;
          else                                         state_n = SHIFT;
        end else begin
          state_n = IDLE;
        end
      end
      SHIFT:   if (cnt == DW'(1)) state_n = DONE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      S   <= '0;
      hop <= OP_XFER;
      cnt <= '0;
    end else if (accept) begin
      S   <= (H == OP_CLR) ? '0 : F;
      hop <= H;
      cnt <= D;
    end else if (state == SHIFT) begin
      S   <= step;
      cnt <= cnt - DW'(1);
    end
  end

`ifdef UNIDAD_CORR_CARRY_EN
  always_ff @(posedge clk) begin
    if (rst || accept)       C <= 1'b0;
    else if (state == SHIFT) C <= step_c;
  end
`else
  logic unused_c;
  assign unused_c = step_c;
`endif

endmodule

// File: tb/tb_unidad_corrimiento_secuencial.sv
// Directed bench for unidad_corrimiento_secuencial (N=8) with immediate-assertion checks.
module tb_unidad_corrimiento_secuencial;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic signed [7:0] F;
  logic        [2:0] H;
  logic        [2:0] D;
  logic              ready, busy, done;
  logic signed [7:0] S;
`ifdef UNIDAD_CORR_CARRY_EN
  logic              C;
`endif

  int cmp = 0;
  int errs = 0;

  unidad_corrimiento_secuencial #(.N(8)) dut (
    .clk(clk), .rst(rst), .start(start), .F(F), .H(H), .D(D),
    .ready(ready), .busy(busy), .done(done),
`ifdef UNIDAD_CORR_CARRY_EN
    .C(C),
`endif
    .S(S)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_c(input string tag, input logic ec);
`ifdef UNIDAD_CORR_CARRY_EN
    chk(tag, {31'd0, C}, {31'd0, ec});
`else
    if (ec === 1'bx) $display("no carry for %s", tag);
`endif
  endtask

  // Start in cycle 0, then follow the op to its done cycle and one cycle past it.
  task automatic do_op(input string tag, input logic [7:0] f, input logic [2:0] h,
                       input logic [2:0] d, input int lat, input logic [7:0] es, input logic ec);
    int   n;
    logic bok;
    chk({tag, ".ready"}, {31'd0, ready}, 32'd1);
    F = f; H = h; D = d; start = 1'b1;
    tick();
    start = 1'b0;
    n = 1; bok = 1'b1;
    while (!done && n < 40) begin
      if (busy !== (n < lat)) bok = 1'b0;
      tick();
      n++;
    end
    chk({tag, ".lat"},  n, lat);
    chk({tag, ".busy"}, {31'd0, bok & ~busy}, 32'd1);
    chk({tag, ".S"},    {24'd0, S}, {24'd0, es});
    chk_c({tag, ".C"}, ec);
    tick();
    chk({tag, ".hold"}, {23'd0, done, S}, {23'd0, 1'b0, es});
  endtask

  initial begin
    int n;
    logic seen;
    rst = 1'b1; start = 1'b0; F = '0; H = '0; D = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst.state", {29'd0, ready, busy, done}, {29'd0, 3'b100});
    chk("rst.S", {24'd0, S}, 32'd0);
    chk_c("rst.C", 1'b0);

    // Reset in cycle 2 of a shl D=5 aborts it without a done pulse
    F = 8'b1001_0110; H = 3'b001; D = 3'd5; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    rst = 1'b1; seen = 1'b0;
    tick(); if (done) seen = 1'b1;
    tick(); if (done) seen = 1'b1;
    rst = 1'b0;
    chk("abort.state", {29'd0, ready, busy, done}, {29'd0, 3'b100});
    chk("abort.S", {24'd0, S}, 32'd0);
    chk_c("abort.C", 1'b0);
    for (int i = 0; i < 8; i++) begin tick(); if (done) seen = 1'b1; end
    chk("abort.nodone", {31'd0, seen}, 32'd0);

    do_op("shl3",  8'b1001_0110, 3'b001, 3'd3, 4, 8'b1011_0000, 1'b0);
    do_op("asr2",  8'b1001_0110, 3'b111, 3'd2, 3, 8'b1110_0101, 1'b1);
    do_op("ror3",  8'b1001_0110, 3'b101, 3'd3, 4, 8'b1101_0010, 1'b1);
    do_op("rol7",  8'b0000_0001, 3'b100, 3'd7, 8, 8'b1000_0000, 1'b0);
    do_op("rol0",  8'b0000_0001, 3'b100, 3'd0, 1, 8'b0000_0001, 1'b0);
    do_op("clr",   8'b1111_1111, 3'b011, 3'd4, 1, 8'b0000_0000, 1'b0);
    do_op("xfer",  8'b0011_1100, 3'b000, 3'd6, 1, 8'b0011_1100, 1'b0);
    do_op("shr4",  8'b1001_0110, 3'b010, 3'd4, 5, 8'b0000_1001, 1'b0);
    do_op("asl1",  8'b1001_0110, 3'b110, 3'd1, 2, 8'b0010_1100, 1'b1);
    do_op("asrp6", 8'b0100_0000, 3'b111, 3'd6, 7, 8'b0000_0001, 1'b0);

    // start with a new F during SHIFT must be ignored
    F = 8'b1001_0110; H = 3'b001; D = 3'd5; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    F = 8'hFF; H = 3'b011; D = 3'd0; start = 1'b1;
    tick(); start = 1'b0;
    n = 3;
    while (!done && n < 40) begin tick(); n++; end
    chk("ign.lat", n, 6);
    chk("ign.S", {24'd0, S}, 32'h0000_00C0);
    tick();

    // start held high: alternate shr D=1 and transfer, reloading in each DONE cycle
    start = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) begin F = 8'h80 >> k; H = 3'b010; D = 3'd1; end
      else            begin F = 8'h5A + 8'(k); H = 3'b000; D = 3'd3; end
      n = 0;
      do begin tick(); n++; end while (!done && n < 10);
      chk($sformatf("b2b%0d.lat", k), n, (k % 2 == 0) ? 2 : 1);
      chk($sformatf("b2b%0d.S", k), {24'd0, S},
          (k % 2 == 0) ? {24'd0, 8'h40 >> k} : {24'd0, 8'h5A + 8'(k)});
    end
    start = 1'b0;
    tick();
    chk("b2b.idle", {29'd0, ready, busy, done}, {29'd0, 3'b100});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end

endmodule

// File: doc/unidad_corrimiento_secuencial.md
# unidad_corrimiento_secuencial

Sequential, parametrised shift/rotate unit. Applies one single-bit shift or rotate per clock under a start/ready/done handshake. It replaces the single-cycle combinational shifter where area matters more than latency, and it sits on the datapath between the operand register and the result bus. It keeps the same operation encoding (H) as the combinational unit and adds a full 0..N-1 shift range, a busy/done protocol and an optional carry-out.

## Interface
- N, default 8: data width, N ≥ 2.
- DW, default $clog2(N): shift-amount width (derived, do not override).
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only while ready=1.
- F  in  N  signed operand; captured on accepted start.
- H  in  3  operation select; captured on accepted start.
- D  in  DW  shift count 0..N-1; captured on accepted start.
- ready  out  1  high in IDLE and DONE.
- busy  out  1  high in SHIFT.
- done  out  1  one-cycle pulse, high in DONE.
- S  out  N  signed result register; holds until the next accepted start.
- C  out  1  carry-out; present only with UNIDAD_CORR_CARRY_EN.

## Operation
- H encoding:
  - 000: transfer.
  - 001: shl, 0 fill.
  - 010: shr, 0 fill.
  - 011: clear to 0.
  - 100: rol.
  - 101: ror.
  - 110: asl, same as shl.
  - 111: asr, sign fill from the current MSB.
- FSM states are IDLE, SHIFT and DONE.
- IDLE/DONE with start=1 (accepted):
  - S ← F (or 0 if H=011); latch H; cnt ← D.
  - If H ∈ {000, 011} or D=0: next state DONE.
  - Otherwise: next state SHIFT.
- IDLE/DONE with start=0: DONE → IDLE; IDLE stays.
- SHIFT:
  - Each edge applies one 1-bit op of the latched H to S; cnt ← cnt−1.
  - When cnt=1, the next state is DONE.
  - start is ignored in SHIFT; F, H and D may change freely without effect.
- Arithmetic: all operations are exactly N bits wide. Bits shifted out are discarded, except into C.
- Back-to-back: a start seen in DONE is accepted. done pulses for the old result and the new operation loads on the same edge.
- Reset:
  - state=IDLE, S=0, cnt=0, done=0, busy=0, ready=1, C=0.
  - A reset mid-SHIFT aborts the operation with no done pulse.
  - rst has priority over start.

## Timing
- Cycle numbering: start is high in cycle 0 (accepted at the edge ending cycle 0).
- Shifting ops with D ≥ 1:
  - busy is high in cycles 1..D.
  - done is high in cycle D+1.
  - S is final from cycle D+1.
- Transfer, clear, or D=0: done in cycle 1; busy never rises.
- Throughput: one operation per D+1 cycles (one per cycle for zero-shift ops with back-to-back starts).
- S changes only on the load edge and the shift edges. It is otherwise stable, including after done.
- ready = !busy, combinationally from the state.

## Configuration
- UNIDAD_CORR_CARRY_EN defined: adds output C, a register updated on every shift edge.
  - shl/asl: C = the MSB before the shift.
  - shr/asr: C = the LSB before the shift.
  - rol/ror: C = the bit that wrapped around.
  - On an accepted start, C ← 0. It therefore stays 0 for transfer, clear and D=0.
- UNIDAD_CORR_CARRY_EN undefined: port C and its register do not exist; behaviour is otherwise identical.

## Test plan
- Reset: hold rst 2 cycles mid-operation (shl, D=5, in cycle 2) -> S=0, busy=0, ready=1, done never pulses, C=0.
- N=8, F=1001_0110, H=001, D=3 -> busy in cycles 1–3, done in cycle 4, S=1011_0000, C=0.
- F=1001_0110, H=111, D=2 -> done in cycle 3, S=1110_0101, C=1. Same F with H=101, D=3 -> S=1101_0010, C=1.
- F=0000_0001, H=100, D=7 -> done in cycle 8, S=1000_0000, C=0. With D=0 -> done in cycle 1, S=0000_0001.
- H=011, F=1111_1111 -> done in cycle 1, S=0. start pulsed with new F during SHIFT -> ignored, result unchanged.
- start held high continuously, ops alternating shr D=1 and transfer -> each new operation is accepted in the DONE cycle, a done pulse is seen for every operation, and no operation is lost.
